// File: rtl/mips_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the multi-cycle MIPS core. It holds the core in reset for
// a programmable number of cycles after start, then enables the core and
// counts RUN cycles. A run ends on a halt request from the core, on a PC stall
// (the same valid PC observed too many times in a row) or on a cycle budget.
// After a stop the core is kept enabled for a short drain phase. It then sits
// in DONE with its clock enable low, so its state can be inspected.
//
// Parameters
//   CNT_W        width of the RUN cycle counter
//   PC_W         width of the observed PC
//   RESET_CYCLES cycles core_rst_n stays low after start (>= 1)
//   MAX_CYCLES   RUN cycle budget, 0 disables the timeout
//   STALL_LIMIT  equal consecutive valid PC compares that count as a stall,
//                0 disables stall detection
//   DRAIN_CYCLES cycles the core stays enabled after a stop, 0 skips draining
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        start/restart pulse, honoured in IDLE and DONE only
//   halt_req     halt request from the core, looked at in RUN only
//   pc_valid     pc carries a fetched instruction address this cycle
//   pc           current core PC
//   core_rst_n   active-low reset to the core
//   core_en      clock enable to the core
//   running      high while in RUN
//   done         high in DONE, sticky until start or rst_n
//   cause        0 none, 1 halt, 2 stall, 3 timeout (valid in DRAIN/DONE)
//   cycle_cnt    RUN cycles elapsed, saturating
// -----------------------------------------------------------------------------
module mips_run_ctrl #(
   parameter int CNT_W        = 32,
   parameter int PC_W         = 32,
   parameter int RESET_CYCLES = 1,
   parameter int MAX_CYCLES   = 72,
   parameter int STALL_LIMIT  = 8,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_req,
   input  logic             pc_valid,
   input  logic [PC_W-1:0]  pc,
   output logic             core_rst_n,
   output logic             core_en,
   output logic             running,
   output logic             done,
   output logic [1:0]       cause,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int HOLD_W  = $clog2(RESET_CYCLES + 2);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
   localparam int STALL_W = $clog2(STALL_LIMIT + 2);

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      RUN,
      DRAIN,
      DONE
   } runStateT;

   runStateT            state;
   runStateT            stateNext;
   logic [HOLD_W-1:0]   holdCnt;
   logic [HOLD_W-1:0]   holdCntNext;
   logic [DRAIN_W-1:0]  drainCnt;
   logic [DRAIN_W-1:0]  drainCntNext;
   logic [STALL_W-1:0]  stallCnt;
   logic [STALL_W-1:0]  stallCntNext;
   logic [PC_W-1:0]     pcLast;
   logic [PC_W-1:0]     pcLastNext;
   logic                pcLoaded;
   logic                pcLoadedNext;
   logic [CNT_W-1:0]    cycleCntNext;
   logic [1:0]          causeNext;
   logic                stallHit;
   logic                timeoutHit;

   // The stall and timeout conditions use registered state and the current
   // inputs, so a stop lands on the same edge that is counted as the final
   // RUN cycle. A stall needs a previously loaded PC. Without that, the
   // first valid sample after RUN entry could match a stale pcLast.
   assign stallHit   = (STALL_LIMIT != 0) && pc_valid && pcLoaded &&
                       (pc == pcLast) &&
                       (stallCnt == STALL_W'(STALL_LIMIT - 1));
   assign timeoutHit = (MAX_CYCLES != 0) &&
                       (cycle_cnt == CNT_W'(MAX_CYCLES - 1));

   // The core-facing controls and status flags depend only on the state, so
   // they take their reset values as soon as the state returns to IDLE.
   assign core_rst_n = (state == RUN) || (state == DRAIN) || (state == DONE);
   assign core_en    = (state == RUN) || (state == DRAIN);
   assign running    = (state == RUN);
   assign done       = (state == DONE);

   // This block computes the next state and the next values of the datapath.
   // In IDLE and DONE, start loads the hold counter and clears the run
   // statistics, so a restart behaves the same as a first run. In RUN the
   // cycle counter and the stall tracker advance. When several stop
   // conditions occur together, halt wins over stall and stall wins over
   // timeout.
   always_comb begin
      stateNext    = state;
      holdCntNext  = holdCnt;
      drainCntNext = drainCnt;
      stallCntNext = stallCnt;
      pcLastNext   = pcLast;
      pcLoadedNext = pcLoaded;
      cycleCntNext = cycle_cnt;
      causeNext    = cause;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               stateNext    = HOLD;
               holdCntNext  = HOLD_W'(RESET_CYCLES);
               stallCntNext = '0;
               pcLastNext   = '0;
               pcLoadedNext = 1'b0;
               cycleCntNext = '0;
               causeNext    = 2'd0;
            end
         end
         HOLD: begin
            if (holdCnt <= HOLD_W'(1)) begin
               stateNext = RUN;
            end else begin
               holdCntNext = holdCnt - 1'b1;
            end
         end
         RUN: begin
            if (cycle_cnt != '1) begin
               cycleCntNext = cycle_cnt + 1'b1;
            end
            if (pc_valid) begin
               if (pcLoaded && (pc == pcLast)) begin
                  stallCntNext = stallCnt + 1'b1;
               end else begin
                  stallCntNext = '0;
               end
               pcLastNext   = pc;
               pcLoadedNext = 1'b1;
            end
            if (halt_req || stallHit || timeoutHit) begin
               if (halt_req) begin
                  causeNext = 2'd1;
               end else if (stallHit) begin
                  causeNext = 2'd2;
               end else begin
                  causeNext = 2'd3;
               end
               if (DRAIN_CYCLES != 0) begin
                  stateNext    = DRAIN;
                  drainCntNext = DRAIN_W'(DRAIN_CYCLES);
               end else begin
                  stateNext = DONE;
               end
            end
         end
         DRAIN: begin
            if (drainCnt <= DRAIN_W'(1)) begin
               stateNext = DONE;
            end else begin
               drainCntNext = drainCnt - 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // This is the state and datapath register. The synchronous reset puts
   // every register back to zero and returns the controller to IDLE. This
   // happens in any state, including in the middle of a run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         holdCnt   <= '0;
         drainCnt  <= '0;
         stallCnt  <= '0;
         pcLast    <= '0;
         pcLoaded  <= 1'b0;
         cycle_cnt <= '0;
         cause     <= 2'd0;
      end else begin
         state     <= stateNext;
         holdCnt   <= holdCntNext;
         drainCnt  <= drainCntNext;
         stallCnt  <= stallCntNext;
         pcLast    <= pcLastNext;
         pcLoaded  <= pcLoadedNext;
         cycle_cnt <= cycleCntNext;
         cause     <= causeNext;
      end
   end

endmodule
